// File: rtl/gen3_packet_assembler.sv
// Gen3 packet assembler: speculative byte buffer plus descriptor FIFO that turns the classified framing byte stream into sop/eop packets.
// Define GEN3_PKT_ASM_STATS_EN to build the drop/nullify counters; otherwise both count ports are tied to zero.
module gen3_packet_assembler #(
    parameter int          BUF_AW  = 11,
    parameter int          DESC_AW = 3,
    parameter logic [11:0] MAX_LEN = 12'd4095
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [5:0]  in_type,
    input  logic [7:0]  in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_data,
    output logic        out_sop,
    output logic        out_eop,
    output logic        out_kind,
    output logic        framing_err,
    output logic [15:0] drop_cnt,
    output logic [15:0] nullify_cnt
);

    // state | meaning
    // IDLE  | between packets, waiting for a start byte
    // TLP   | collecting TLP payload bytes speculatively
    // DLLP  | collecting DLLP payload bytes speculatively
    // DROP  | packet already discarded, swallowing bytes until its end
    typedef enum logic [1:0] {S_IDLE, S_TLP, S_DLLP, S_DROP} state_t;

    localparam logic [5:0] T_DATA   = 6'b100000;
    localparam logic [5:0] T_TSTART = 6'b010000;
    localparam logic [5:0] T_TEND   = 6'b001000;
    localparam logic [5:0] T_DEND   = 6'b000100;
    localparam logic [5:0] T_DSTART = 6'b000010;
    localparam logic [5:0] T_EDB    = 6'b000001;

    localparam int BUF_DEPTH_I  = 1 << BUF_AW;
    localparam int DESC_DEPTH_I = 1 << DESC_AW;
    localparam logic [BUF_AW:0]  BUF_DEPTH  = (BUF_AW + 1)'(BUF_DEPTH_I);
    localparam logic [DESC_AW:0] DESC_DEPTH = (DESC_AW + 1)'(DESC_DEPTH_I);
    localparam logic [BUF_AW:0]  PTR_ONE    = (BUF_AW + 1)'(1);
    localparam logic [DESC_AW:0] DPTR_ONE   = (DESC_AW + 1)'(1);

    state_t state;

    logic [BUF_AW:0]  wr_ptr;
    logic [BUF_AW:0]  base_ptr;
    logic [BUF_AW:0]  rd_ptr;
    logic [BUF_AW:0]  used;
    logic [11:0]      len_cnt;
    logic [11:0]      rd_idx;

    logic [DESC_AW:0] d_wr;
    logic [DESC_AW:0] d_rd;
    logic [DESC_AW:0] d_used;

    logic [7:0]  byte_mem [0:BUF_DEPTH_I-1];
    logic [12:0] desc_mem [0:DESC_DEPTH_I-1];

    logic        take;
    logic        in_pkt;
    logic        good_end;
    logic        has_space;
    logic        desc_full;
    logic        desc_empty;
    logic        buf_we;
    logic        desc_push;
    logic [11:0] head_len;
    logic        head_kind;
    logic        head_last;
    logic        xfer;

    assign take       = in_valid && (in_type != 6'b000000);
    assign in_pkt     = (state == S_TLP) || (state == S_DLLP);
    assign good_end   = ((state == S_TLP)  && (in_type == T_TEND)) ||
                        ((state == S_DLLP) && (in_type == T_DEND));

    // Occupancy covers committed-but-unread bytes and the packet being assembled.
    assign used       = wr_ptr - rd_ptr;
    assign has_space  = used < BUF_DEPTH;
    assign d_used     = d_wr - d_rd;
    assign desc_full  = d_used == DESC_DEPTH;
    assign desc_empty = d_used == '0;

    assign buf_we    = take && in_pkt && (in_type == T_DATA) && has_space && (len_cnt < MAX_LEN);
    assign desc_push = take && good_end && (len_cnt != 12'd0) && !desc_full;

    assign {head_kind, head_len} = desc_mem[d_rd[DESC_AW-1:0]];
    assign head_last = rd_idx == (head_len - 12'd1);
    assign xfer      = !desc_empty && out_ready;

    assign out_valid = !desc_empty;
    assign out_data  = desc_empty ? 8'h00 : byte_mem[rd_ptr[BUF_AW-1:0]];
    assign out_sop   = !desc_empty && (rd_idx == 12'd0);
    assign out_eop   = !desc_empty && head_last;
    assign out_kind  = !desc_empty && head_kind;

    always_ff @(posedge clk) begin
        if (buf_we) begin
            byte_mem[wr_ptr[BUF_AW-1:0]] <= in_data;
        end
        if (desc_push) begin
            desc_mem[d_wr[DESC_AW-1:0]] <= {(state == S_DLLP), len_cnt};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            wr_ptr      <= '0;
            base_ptr    <= '0;
            len_cnt     <= 12'd0;
            framing_err <= 1'b0;
        end else begin
            framing_err <= 1'b0;
            if (take) begin
                case (state)
                    S_IDLE: begin
                        if (in_type == T_TSTART) begin
                            state    <= S_TLP;
                            base_ptr <= wr_ptr;
                            len_cnt  <= 12'd0;
                        end else if (in_type == T_DSTART) begin
                            state    <= S_DLLP;
                            base_ptr <= wr_ptr;
                            len_cnt  <= 12'd0;
                        end else begin
                            framing_err <= 1'b1;
                        end
                    end
                    S_TLP, S_DLLP: begin
                        if (in_type == T_DATA) begin
                            if (buf_we) begin
                                wr_ptr  <= wr_ptr + PTR_ONE;
                                len_cnt <= len_cnt + 12'd1;
                            end else begin
                                wr_ptr <= base_ptr;
                                state  <= S_DROP;
                            end
                        end else if ((in_type == T_TSTART) || (in_type == T_DSTART)) begin
                            // Abandon the open packet; the new one reuses its buffer space.
                            wr_ptr      <= base_ptr;
                            len_cnt     <= 12'd0;
                            framing_err <= 1'b1;
                            state       <= (in_type == T_TSTART) ? S_TLP : S_DLLP;
                        end else if (good_end) begin
                            if (desc_push) begin
                                base_ptr <= wr_ptr;
                            end else begin
                                wr_ptr <= base_ptr;
                            end
                            state <= S_IDLE;
                        end else if ((state == S_TLP) && (in_type == T_EDB)) begin
                            wr_ptr <= base_ptr;
                            state  <= S_IDLE;
                        end else begin
                            wr_ptr      <= base_ptr;
                            framing_err <= 1'b1;
                            state       <= S_IDLE;
                        end
                    end
                    S_DROP: begin
                        if (in_type == T_TSTART) begin
                            state   <= S_TLP;
                            len_cnt <= 12'd0;
                        end else if (in_type == T_DSTART) begin
                            state   <= S_DLLP;
                            len_cnt <= 12'd0;
                        end else if ((in_type == T_TEND) || (in_type == T_DEND) || (in_type == T_EDB)) begin
                            state <= S_IDLE;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_wr   <= '0;
            d_rd   <= '0;
            rd_ptr <= '0;
            rd_idx <= 12'd0;
        end else begin
            if (desc_push) begin
                d_wr <= d_wr + DPTR_ONE;
            end
            if (xfer) begin
                rd_ptr <= rd_ptr + PTR_ONE;
                if (head_last) begin
                    d_rd   <= d_rd + DPTR_ONE;
                    rd_idx <= 12'd0;
                end else begin
                    rd_idx <= rd_idx + 12'd1;
                end
            end
        end
    end

`ifdef GEN3_PKT_ASM_STATS_EN
    logic        drop_ev;
    logic        null_ev;
    logic [15:0] drop_q;
    logic [15:0] null_q;

    assign drop_ev = take && ((good_end && !desc_push) ||
                     ((state == S_DROP) && (in_type != T_DATA)));
    assign null_ev = take && (state == S_TLP) && (in_type == T_EDB);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            drop_q <= 16'h0000;
            null_q <= 16'h0000;
        end else begin
            if (drop_ev && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'h0001;
            end
            if (null_ev && (null_q != 16'hFFFF)) begin
                null_q <= null_q + 16'h0001;
            end
        end
    end

    assign drop_cnt    = drop_q;
    assign nullify_cnt = null_q;
`else
    assign drop_cnt    = 16'h0000;
    assign nullify_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_gen3_packet_assembler.sv
// Bench for gen3_packet_assembler (small buffer build): vector table, directed corner cases and random traffic against a queue-based model.
module tb_gen3_packet_assembler;

    localparam int BA = 3;
    localparam int DA = 3;
    localparam logic [11:0] ML = 12'd4095;
    localparam int DEPTH  = 1 << BA;
    localparam int DDEPTH = 1 << DA;

    localparam logic [5:0] T_NONE = 6'b000000;
    localparam logic [5:0] T_DATA = 6'b100000;
    localparam logic [5:0] T_TS   = 6'b010000;
    localparam logic [5:0] T_TE   = 6'b001000;
    localparam logic [5:0] T_DE   = 6'b000100;
    localparam logic [5:0] T_DS   = 6'b000010;
    localparam logic [5:0] T_EDB  = 6'b000001;

`ifdef GEN3_PKT_ASM_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [5:0]  in_type;
    logic [7:0]  in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_sop;
    logic        out_eop;
    logic        out_kind;
    logic        framing_err;
    logic [15:0] drop_cnt;
    logic [15:0] nullify_cnt;

    gen3_packet_assembler #(.BUF_AW(BA), .DESC_AW(DA), .MAX_LEN(ML)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_type(in_type), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_sop(out_sop), .out_eop(out_eop), .out_kind(out_kind),
        .framing_err(framing_err), .drop_cnt(drop_cnt), .nullify_cnt(nullify_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: committed bytes and packet lengths as queues, open packet as its own queue.
    localparam int M_IDLE = 0, M_TLP = 1, M_DLLP = 2, M_DROP = 3;
    logic [7:0] cb[$];
    int         lens[$];
    bit         kinds[$];
    logic [7:0] sb[$];
    int         ridx;
    int         mmode;
    bit         m_err;
    int         m_drop;
    int         m_null;

    int rdy_pct = 100;

    typedef struct {
        logic [5:0]  t;
        logic [7:0]  d;
        logic        r;
        logic [11:0] exp;
    } vec_t;
    vec_t tv[12];

    logic [7:0] exp_b [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 65535) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        cb.delete(); lens.delete(); kinds.delete(); sb.delete();
        ridx = 0; mmode = M_IDLE; m_err = 1'b0; m_drop = 0; m_null = 0;
    endtask

    task automatic model_step();
        bit space;
        bit full;
        space = (cb.size() + sb.size()) < DEPTH;
        full  = lens.size() == DDEPTH;
        m_err = 1'b0;
        if (lens.size() > 0 && out_ready) begin
            void'(cb.pop_front());
            ridx++;
            if (ridx == lens[0]) begin
                void'(lens.pop_front());
                void'(kinds.pop_front());
                ridx = 0;
            end
        end
        if (in_valid && in_type != T_NONE) begin
            case (mmode)
                M_IDLE: begin
                    if (in_type == T_TS) begin mmode = M_TLP; sb.delete(); end
                    else if (in_type == T_DS) begin mmode = M_DLLP; sb.delete(); end
                    else m_err = 1'b1;
                end
                M_TLP, M_DLLP: begin
                    if (in_type == T_DATA) begin
                        if (space && sb.size() < int'(ML)) sb.push_back(in_data);
                        else begin sb.delete(); mmode = M_DROP; end
                    end else if (in_type == T_TS || in_type == T_DS) begin
                        sb.delete(); m_err = 1'b1;
                        mmode = (in_type == T_TS) ? M_TLP : M_DLLP;
                    end else if ((mmode == M_TLP && in_type == T_TE) || (mmode == M_DLLP && in_type == T_DE)) begin
                        if (sb.size() > 0 && !full) begin
                            foreach (sb[i]) cb.push_back(sb[i]);
                            lens.push_back(sb.size());
                            kinds.push_back(mmode == M_DLLP);
                        end else m_drop = sat(m_drop);
                        sb.delete(); mmode = M_IDLE;
                    end else if (mmode == M_TLP && in_type == T_EDB) begin
                        sb.delete(); m_null = sat(m_null); mmode = M_IDLE;
                    end else begin
                        sb.delete(); m_err = 1'b1; mmode = M_IDLE;
                    end
                end
                default: begin
                    if (in_type == T_TS) begin m_drop = sat(m_drop); mmode = M_TLP; end
                    else if (in_type == T_DS) begin m_drop = sat(m_drop); mmode = M_DLLP; end
                    else if (in_type != T_DATA) begin m_drop = sat(m_drop); mmode = M_IDLE; end
                end
            endcase
        end
    endtask

    task automatic check_all();
        bit ev;
        ev = lens.size() > 0;
        chk("valid", out_valid, ev);
        if (ev) chk("beat", {out_data, out_sop, out_eop, out_kind},
                    {cb[0], ridx == 0, ridx == lens[0] - 1, kinds[0]});
        chk("framing_err", framing_err, m_err);
        chk("counters", {drop_cnt, nullify_cnt},
            {STATS ? m_drop[15:0] : 16'h0, STATS ? m_null[15:0] : 16'h0});
    endtask

    task automatic step(input logic [5:0] t, input logic [7:0] d, input logic v, input logic r);
        in_type = t; in_data = d; in_valid = v; out_ready = r;
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic sb_in(input logic [5:0] t, input logic [7:0] d, input logic r);
        step(t, d, 1'b1, r);
    endtask

    task automatic stepr(input logic [5:0] t, input logic [7:0] d, input logic v);
        step(t, d, v, $urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic expect_pkt(input string name, input int n, input logic kind);
        int got = 0;
        int cyc = 0;
        while (got < n && cyc < 40) begin
            if (out_valid) begin
                chk({name, "_data"}, out_data, exp_b[got]);
                chk({name, "_sop"},  out_sop,  got == 0);
                chk({name, "_eop"},  out_eop,  got == n - 1);
                chk({name, "_kind"}, out_kind, kind);
                got++;
            end
            step(T_NONE, 8'h00, 1'b0, 1'b1);
            cyc++;
        end
        chk({name, "_count"}, got, n);
        chk({name, "_after"}, out_valid, 1'b0);
    endtask

    function automatic vec_t mkv(input logic [5:0] t, input logic [7:0] d, input logic [11:0] e);
        vec_t v;
        v.t = t; v.d = d; v.r = 1'b1; v.exp = e;
        return v;
    endfunction

    initial begin
        in_valid = 1'b0; in_type = T_NONE; in_data = 8'h00; out_ready = 1'b0;
        rst = 1'b1;
        #1 rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("reset_out", {out_valid, out_data, out_sop, out_eop, out_kind, framing_err}, 0);
        chk("reset_cnt", {drop_cnt, nullify_cnt}, 0);
        rst = 1'b1;
        @(negedge clk);

        // Vector table: 5-byte TLP, exp = {valid, data, sop, eop, kind}.
        tv[0]  = mkv(T_TS,   8'h00, {1'b0, 8'h00, 3'b000});
        for (int i = 1; i <= 5; i++) tv[i] = mkv(T_DATA, 8'(i), {1'b0, 8'h00, 3'b000});
        tv[6]  = mkv(T_TE,   8'h00, {1'b1, 8'h01, 3'b100});
        tv[7]  = mkv(T_NONE, 8'h00, {1'b1, 8'h02, 3'b000});
        tv[8]  = mkv(T_NONE, 8'h00, {1'b1, 8'h03, 3'b000});
        tv[9]  = mkv(T_NONE, 8'h00, {1'b1, 8'h04, 3'b000});
        tv[10] = mkv(T_NONE, 8'h00, {1'b1, 8'h05, 3'b010});
        tv[11] = mkv(T_NONE, 8'h00, {1'b0, 8'h00, 3'b000});
        for (int i = 0; i < 12; i++) begin
            step(tv[i].t, tv[i].d, tv[i].t != T_NONE, tv[i].r);
            chk($sformatf("t1_row%0d", i),
                {out_valid, out_valid ? {out_data, out_sop, out_eop, out_kind} : 11'h000}, tv[i].exp);
        end

        // DLLP held under back-pressure, then drained.
        sb_in(T_DS, 8'h00, 1'b0);
        for (int i = 0; i < 6; i++) begin
            exp_b[i] = 8'h10 + 8'(i);
            sb_in(T_DATA, exp_b[i], 1'b0);
        end
        sb_in(T_DE, 8'h00, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(T_NONE, 8'h00, 1'b0, 1'b0);
            chk("t2_hold", {out_valid, out_data, out_sop, out_kind}, {1'b1, 8'h10, 1'b1, 1'b1});
        end
        expect_pkt("t2", 6, 1'b1);

        // EDB nullifies, next TLP survives, then a packet that exactly fills the buffer.
        sb_in(T_TS, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) sb_in(T_DATA, 8'h60 + 8'(i), 1'b1);
        sb_in(T_EDB, 8'h00, 1'b1);
        sb_in(T_TS, 8'h00, 1'b1);
        sb_in(T_DATA, 8'hAA, 1'b1);
        sb_in(T_DATA, 8'hBB, 1'b1);
        sb_in(T_TE, 8'h00, 1'b1);
        exp_b[0] = 8'hAA; exp_b[1] = 8'hBB;
        expect_pkt("t3", 2, 1'b0);
        chk("t3_nullify", nullify_cnt, STATS ? 16'd1 : 16'd0);
        sb_in(T_TS, 8'h00, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            exp_b[i] = 8'h30 + 8'(i);
            sb_in(T_DATA, exp_b[i], 1'b0);
        end
        sb_in(T_TE, 8'h00, 1'b0);
        expect_pkt("t3_full", DEPTH, 1'b0);

        // Overflowing TLP is dropped, following DLLP intact.
        sb_in(T_TS, 8'h00, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) sb_in(T_DATA, 8'h70 + 8'(i), 1'b1);
        sb_in(T_TE, 8'h00, 1'b1);
        step(T_NONE, 8'h00, 1'b0, 1'b1);
        chk("t4_noout", out_valid, 1'b0);
        chk("t4_drop", drop_cnt, STATS ? 16'd1 : 16'd0);
        sb_in(T_DS, 8'h00, 1'b1);
        sb_in(T_DATA, 8'hC1, 1'b1);
        sb_in(T_DATA, 8'hC2, 1'b1);
        sb_in(T_DE, 8'h00, 1'b1);
        exp_b[0] = 8'hC1; exp_b[1] = 8'hC2;
        expect_pkt("t4", 2, 1'b1);

        // Wrong end type and a stray data byte in IDLE.
        sb_in(T_TS, 8'h00, 1'b1);
        sb_in(T_DATA, 8'h01, 1'b1);
        sb_in(T_DATA, 8'h02, 1'b1);
        sb_in(T_DE, 8'h00, 1'b1);
        chk("t5_err_on", framing_err, 1'b1);
        step(T_NONE, 8'h00, 1'b0, 1'b1);
        chk("t5_err_off", {framing_err, out_valid}, 2'b00);
        sb_in(T_DATA, 8'h55, 1'b1);
        chk("t5_idle_err", framing_err, 1'b1);
        step(T_NONE, 8'h00, 1'b0, 1'b1);
        chk("t5_idle_off", {framing_err, out_valid}, 2'b00);

        // Asynchronous reset with a queued packet and one mid-assembly.
        sb_in(T_TS, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) sb_in(T_DATA, 8'h90 + 8'(i), 1'b0);
        sb_in(T_TE, 8'h00, 1'b0);
        sb_in(T_TS, 8'h00, 1'b0);
        sb_in(T_DATA, 8'hEE, 1'b0);
        sb_in(T_DATA, 8'hEF, 1'b0);
        chk("t6_pre", out_valid, 1'b1);
        in_valid = 1'b0; in_type = T_NONE;
        #2 rst = 1'b0;
        #1;
        chk("t6_rst_out", {out_valid, out_data, out_sop, out_eop, out_kind, framing_err}, 0);
        chk("t6_rst_cnt", {drop_cnt, nullify_cnt}, 0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        sb_in(T_TS, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) begin
            exp_b[i] = 8'hD0 + 8'(i);
            sb_in(T_DATA, exp_b[i], 1'b1);
        end
        sb_in(T_TE, 8'h00, 1'b1);
        expect_pkt("t6", 4, 1'b0);

        // Random traffic checked cycle by cycle against the model.
        for (int p = 0; p < 320; p++) begin
            int lmax;
            int len;
            int e;
            rdy_pct = ((p / 40) % 3 == 0) ? 90 : (((p / 40) % 3 == 1) ? 40 : 5);
            lmax = (rdy_pct == 5) ? 2 : 10;
            repeat ($urandom_range(0, 2)) begin
                if ($urandom_range(0, 1) == 0) stepr(T_NONE, 8'h00, 1'b1);
                else stepr(T_DATA << $urandom_range(0, 5), 8'($urandom), 1'b0);
            end
            if ($urandom_range(0, 99) < 5) stepr(T_DATA, 8'($urandom), 1'b1);
            stepr($urandom_range(0, 1) ? T_DS : T_TS, 8'h00, 1'b1);
            len = $urandom_range(0, lmax);
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 99) < 20) stepr(T_NONE, 8'h00, 1'b0);
                stepr(T_DATA, 8'($urandom), 1'b1);
            end
            e = $urandom_range(0, 99);
            if (e < 70) stepr((mmode == M_DLLP) ? T_DE : T_TE, 8'h00, 1'b1);
            else if (e < 80) stepr(T_EDB, 8'h00, 1'b1);
            else if (e < 90) stepr((mmode == M_DLLP) ? T_TE : T_DE, 8'h00, 1'b1);
        end
        repeat (80) step(T_NONE, 8'h00, 1'b0, 1'b1);
        chk("final_empty", out_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gen3_packet_assembler.md
Name: gen3_packet_assembler

Overview:
- Downstream consumer of the Gen3 per-byte framing checker.
- Takes the classified byte stream (one-hot type plus data byte), stores TLP/DLLP payload bytes in a speculative byte buffer, and commits whole packets on END. EDB or error rewinds the buffer.
- Presents committed packets to the data-link layer as a byte stream with sop/eop and a valid/ready handshake.

Parameters:
- BUF_AW, 11, byte buffer address width; buffer holds 2^BUF_AW bytes.
- DESC_AW, 3, descriptor FIFO address width; holds 2^DESC_AW committed packets.
- MAX_LEN, 12'd4095, largest payload byte count accepted per packet.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  byte qualifier from framing checker.
- in_type  in  6  one-hot: 100000 data, 010000 tlpstart, 001000 tlpend, 000100 dllpend, 000010 dllpstart, 000001 tlpedb, 000000 none.
- in_data  in  8  byte accompanying in_type.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  consumer accepts byte.
- out_data  out  8  payload byte.
- out_sop  out  1  first byte of packet.
- out_eop  out  1  last byte of packet.
- out_kind  out  1  0 = TLP, 1 = DLLP; constant across a packet.
- framing_err  out  1  one-cycle pulse on protocol violation.
- drop_cnt  out  16  packets dropped (overflow or zero length), saturating.
- nullify_cnt  out  16  TLPs nullified by EDB, saturating.

Behaviour:
- Reset (rst=0, async) clears all pointers, FSM to IDLE, every output 0. Any packet being assembled or queued is discarded.
- Input is sampled only when in_valid=1 and in_type!=0. Other cycles hold state.
- Start/end bytes are never stored. Only data bytes go to the buffer.
- FSM states: IDLE, TLP, DLLP, DROP. Registers: wr_ptr (speculative), base_ptr (packet start), rd_ptr, all BUF_AW+1 bits wide. len_cnt is 12 bits.
- IDLE:
  - tlpstart -> TLP; dllpstart -> DLLP. Both set base_ptr=wr_ptr and len_cnt=0.
  - Any other type -> framing_err pulse, stay IDLE.
- TLP/DLLP on data:
  - If buffer has free space (2^BUF_AW - (wr_ptr-rd_ptr) > 0) and len_cnt < MAX_LEN: write byte, wr_ptr++, len_cnt++.
  - Otherwise: wr_ptr=base_ptr, go to DROP.
- TLP on tlpend, or DLLP on dllpend:
  - If len_cnt>0 and descriptor FIFO not full: push {kind,len_cnt}, base_ptr=wr_ptr, go to IDLE.
  - If len_cnt=0 or descriptor FIFO full: rewind, drop_cnt++, go to IDLE.
- TLP on tlpedb: rewind wr_ptr=base_ptr, nullify_cnt++, go to IDLE.
- Wrong end type, or a start while in TLP/DLLP:
  - Rewind the current packet and pulse framing_err.
  - A new start opens a new packet in the same cycle; a wrong end goes to IDLE.
- DROP: ignore data. tlpend, dllpend or tlpedb -> drop_cnt++, go to IDLE. A start -> drop_cnt++, open the new packet.
- Commit latency: the descriptor is visible on the cycle after the end byte; out_valid can rise then.
- Read side:
  - out_valid=1 when the descriptor FIFO is non-empty.
  - out_data=buf[rd_ptr] (combinational read).
  - out_sop when rd_idx=0; out_eop when rd_idx=len-1.
  - A transfer occurs when out_valid&out_ready. On transfer: rd_ptr++, rd_idx++. On eop: pop the descriptor, rd_idx=0.
- out_* are stable while out_valid=1 and out_ready=0.
- Commit/drop and read pop/rd_ptr advance in the same cycle are legal; free space uses the pre-update rd_ptr.
- Pointers wrap modulo 2^(BUF_AW+1); the buffer index is the low BUF_AW bits.
- Counters saturate at 16'hFFFF.

Optional Feature:
- GEN3_PKT_ASM_STATS_EN:
  - Defined: drop_cnt/nullify_cnt count as above.
  - Undefined: counter registers are omitted and both ports are tied to 0. All other behaviour is unchanged.

Test Plan:
- tlpstart, 5 data (01..05), tlpend; out_ready=1 -> 5 bytes out, sop on 01, eop on 05, kind=0, first out_valid 1 cycle after tlpend.
- dllpstart, 6 data, dllpend with out_ready=0 for 10 cycles then 1 -> out_data held at byte0, then 6 bytes, kind=1.
- tlpstart, 3 data, tlpedb, then tlpstart, 2 data AA,BB, tlpend -> nullify_cnt=1, only AA,BB emitted, buffer occupancy 0 afterwards.
- BUF_AW=3: TLP with 9 data bytes -> drop_cnt=1, no output. Following 2-byte DLLP is emitted intact.
- tlpstart, 2 data, dllpend -> framing_err pulses once, packet discarded. Data byte in IDLE -> framing_err, no output.
- rst low mid-TLP with one packet queued -> all outputs 0 immediately. After release, a fresh 4-byte TLP emits correctly.
